// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects and
// write strobes, handshakes with the shared memory, counts retired
// instructions, and traps on illegal opcodes or memory timeout.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   opcode             instruction register bits [6:0]
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory completes the current access this cycle
//   pc_en, pc_src      PC write enable / source (0 ALU result, 1 ALUOut)
//   ir_write           instruction register load
//   mem_read/mem_write memory requests, i_or_d address select
//   alu_src_a/b        ALU operand selects
//   alu_op1, alu_op2   operation class for alu_control (00 = add)
//   reg_write          register file write, mem_to_reg writeback source
//   state              current state encoding
//   illegal, bus_error sticky trap causes
//   instret            retired-instruction counter
module multicycle_control #(
  parameter int unsigned INSTRET_W   = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 pc_src,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 alu_op1,
  output logic                 alu_op2,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd15
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_error_q, bus_error_d;

  logic [CNT_W-1:0]     wait_cnt_inc;
  logic                 timeout_hit;
  logic                 ready_g;

  // Strobes that follow mem_ready are held off while reset is asserted.
  assign ready_g      = mem_ready & ~reset;
  assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
  assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt_inc == CNT_W'(MEM_TIMEOUT));

  // Next-state, counters and datapath control decode.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    instret_d   = instret_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op1     = 1'b0;
    alu_op2     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready_g;
        pc_en     = ready_g;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_DECODE: begin
        // Branch target (old PC + imm) computed early into ALUOut.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_ST: state_d = S_MEM_ADDR;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instret_d  = instret_q + INSTRET_W'(1);
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d   = S_FETCH;
          instret_d = instret_q + INSTRET_W'(1);
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b00;
        alu_op2   = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op2   = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        instret_d = instret_q + INSTRET_W'(1);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1-rs2; taken branch loads the target held in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b00;
        alu_op1   = 1'b1;
        pc_src    = 1'b1;
        pc_en     = zero;
        instret_d = instret_q + INSTRET_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      instret_q   <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instret_q   <= instret_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state     = state_q;
  assign instret   = instret_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;

endmodule
